// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures one decoded instruction per handshake,
// forwards EX/MEM and MEM/WB results onto the held operands and drives the ALU inputs.
module id_ex_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rs1_addr,
   input  logic [4:0]      in_rs2_addr,
   input  logic [4:0]      in_rd_addr,
   input  logic            in_sel_a_pc,
   input  logic            in_sel_b_imm,
   input  logic [3:0]      in_alu_ctrl,
   input  logic            in_reg_write,
   input  logic            flush,
   input  logic            exm_reg_write,
   input  logic [4:0]      exm_rd,
   input  logic [XLEN-1:0] exm_data,
   input  logic            mwb_reg_write,
   input  logic [4:0]      mwb_rd,
   input  logic [XLEN-1:0] mwb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   output logic [4:0]      rd_addr,
   output logic            reg_write,
   output logic [XLEN-1:0] rs2_fwd
);

   logic            valid_q;
   logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [4:0]      rs1_addr_q, rs2_addr_q, rd_q;
   logic            sel_a_pc_q, sel_b_imm_q, reg_write_q;
   logic [3:0]      alu_ctrl_q;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2, b_pre;
   logic            accept, stall;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign stall    = valid_q && !out_ready && !flush;

   // EX/MEM is checked last so it overrides MEM/WB; x0 never forwards.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      fwd_rs2 = rs2_data_q;
      if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs1_addr_q)) fwd_rs1 = mwb_data;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_addr_q)) fwd_rs1 = exm_data;
      if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs2_addr_q)) fwd_rs2 = mwb_data;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_addr_q)) fwd_rs2 = exm_data;
   end

   always_comb begin
      b_pre = sel_b_imm_q ? imm_q : fwd_rs2;
      alu_b = b_pre;
      if (alu_ctrl_q inside {4'd5, 4'd6, 4'd7})
         alu_b = {{(XLEN-5){1'b0}}, b_pre[4:0]};
   end

   assign alu_a     = sel_a_pc_q ? pc_q : fwd_rs1;
   assign alu_ctrl  = alu_ctrl_q;
   assign rd_addr   = rd_q;
   assign reg_write = reg_write_q;
   assign rs2_fwd   = fwd_rs2;
   assign out_valid = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_q        <= '0;
         sel_a_pc_q  <= 1'b0;
         sel_b_imm_q <= 1'b0;
         reg_write_q <= 1'b0;
         alu_ctrl_q  <= '0;
      end else begin
         if (flush)
            valid_q <= 1'b0;
         else if (accept)
            valid_q <= 1'b1;
         else if (valid_q && out_ready)
            valid_q <= 1'b0;

         if (accept && !flush) begin
            pc_q        <= in_pc;
            rs1_data_q  <= in_rs1_data;
            rs2_data_q  <= in_rs2_data;
            imm_q       <= in_imm;
            rs1_addr_q  <= in_rs1_addr;
            rs2_addr_q  <= in_rs2_addr;
            rd_q        <= in_rd_addr;
            sel_a_pc_q  <= in_sel_a_pc;
            sel_b_imm_q <= in_sel_b_imm;
            reg_write_q <= in_reg_write;
            alu_ctrl_q  <= in_alu_ctrl;
         end else if (stall) begin
            // latch forwarded values so a producer retiring mid-stall is kept
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: spec-level model with per-cycle compare,
// an in-order rd scoreboard, and directed literal checks.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic        in_sel_a_pc, in_sel_b_imm, in_reg_write;
   logic [3:0]  in_alu_ctrl;
   logic        flush;
   logic        exm_reg_write, mwb_reg_write;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_data, mwb_data;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b, rs2_fwd;
   logic [3:0]  alu_ctrl;
   logic [4:0]  rd_addr;
   logic        reg_write;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_sel_a_pc(in_sel_a_pc), .in_sel_b_imm(in_sel_b_imm), .in_alu_ctrl(in_alu_ctrl),
      .in_reg_write(in_reg_write), .flush(flush),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .rd_addr(rd_addr), .reg_write(reg_write), .rs2_fwd(rs2_fwd)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1a, rs2a, rd;
      logic        sela, selb, rw;
      logic [3:0]  ctrl;
   } instr_t;

   instr_t     held;
   bit         m_valid;
   bit         acc;
   logic [4:0] rd_q[$];

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
      if (exm_reg_write && exm_rd != 0 && exm_rd == a) return exm_data;
      if (mwb_reg_write && mwb_rd != 0 && mwb_rd == a) return mwb_data;
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0;
         held = '{pc: 0, rs1d: 0, rs2d: 0, imm: 0, rs1a: 0, rs2a: 0, rd: 0,
                  sela: 0, selb: 0, rw: 0, ctrl: 0};
         rd_q.delete();
      end else begin
         acc = in_valid && (!m_valid || out_ready);
         if (flush) begin
            m_valid = 0;
            rd_q.delete();
         end else if (acc) begin
            m_valid = 1;
            held = '{pc: in_pc, rs1d: in_rs1_data, rs2d: in_rs2_data, imm: in_imm,
                     rs1a: in_rs1_addr, rs2a: in_rs2_addr, rd: in_rd_addr,
                     sela: in_sel_a_pc, selb: in_sel_b_imm, rw: in_reg_write, ctrl: in_alu_ctrl};
            rd_q.push_back(in_rd_addr);
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end else if (m_valid) begin
            held.rs1d = fwd(held.rs1a, held.rs1d);
            held.rs2d = fwd(held.rs2a, held.rs2d);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [31:0] ea, eb;
      if (!rst_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_alu_a", alu_a, 0);
         check("rst_alu_b", alu_b, 0);
      end else begin
         check("out_valid", out_valid, m_valid);
         check("in_ready", in_ready, !m_valid || out_ready);
         if (m_valid) begin
            ea = held.sela ? held.pc : fwd(held.rs1a, held.rs1d);
            eb = held.selb ? held.imm : fwd(held.rs2a, held.rs2d);
            if (held.ctrl >= 5 && held.ctrl <= 7) eb = eb % 32;
            check("alu_a", alu_a, ea);
            check("alu_b", alu_b, eb);
            check("alu_ctrl", alu_ctrl, held.ctrl);
            check("rd_addr", rd_addr, held.rd);
            check("reg_write", reg_write, held.rw);
            check("rs2_fwd", rs2_fwd, fwd(held.rs2a, held.rs2d));
         end
         if (out_valid && out_ready) begin
            checks++;
            if (rd_q.size() == 0) begin
               failures++;
               $display("FAIL order consume with nothing outstanding at %0t", $time);
            end else if (rd_addr !== rd_q[0]) begin
               failures++;
               $display("FAIL order_rd actual=%h required=%h at %0t", rd_addr, rd_q[0], $time);
               void'(rd_q.pop_front());
            end else begin
               void'(rd_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] rd, input logic sa, input logic sb,
                            input logic [3:0] ctrl, input logic rw);
      in_valid = 1; in_pc = pc; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
      in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd;
      in_sel_a_pc = sa; in_sel_b_imm = sb; in_alu_ctrl = ctrl; in_reg_write = rw;
   endtask

   task automatic clear_fwd;
      exm_reg_write = 0; exm_rd = 0; exm_data = 0;
      mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
   endtask

   initial begin
      rst_n = 0; flush = 0; out_ready = 1;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 0;
      clear_fwd();

      // reset with random inputs
      for (int i = 0; i < 4; i++) begin
         set_instr($urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
         in_valid = 1'($urandom); out_ready = 1'($urandom);
         exm_reg_write = 1; exm_rd = 5'($urandom); exm_data = $urandom;
         mwb_reg_write = 1; mwb_rd = 5'($urandom); mwb_data = $urandom;
         step();
         check("reset_out_valid", out_valid, 0);
         check("reset_alu_a", alu_a, 0);
         check("reset_alu_b", alu_b, 0);
         check("reset_in_ready", in_ready, 1);
      end
      clear_fwd(); out_ready = 1; in_valid = 0;
      rst_n = 1;
      step();

      // first instruction: ADD x5,x7 with data 10/20
      set_instr(32'h40, 10, 20, 0, 5, 7, 9, 0, 0, 0, 1);
      step();
      in_valid = 0;
      check("first_valid", out_valid, 1);
      check("first_alu_a", alu_a, 10);
      check("first_alu_b", alu_b, 20);
      check("first_alu_ctrl", alu_ctrl, 0);

      // forward priority on held rs1 = x3
      set_instr(32'h44, 32'h11, 32'h22, 0, 3, 6, 10, 0, 0, 0, 1);
      step();
      in_valid = 0; out_ready = 0;
      exm_reg_write = 1; exm_rd = 3; exm_data = 32'hAAAA;
      mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'hBBBB;
      #1 check("fwd_exm_wins", alu_a, 32'hAAAA);
      exm_reg_write = 0;
      #1 check("fwd_mwb", alu_a, 32'hBBBB);
      clear_fwd(); out_ready = 1;
      step();
      set_instr(32'h48, 32'h55, 32'h66, 0, 0, 0, 11, 0, 0, 0, 1);
      step();
      in_valid = 0;
      exm_reg_write = 1; exm_rd = 0; exm_data = 32'hAAAA;
      mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'hBBBB;
      #1 check("fwd_x0_never", alu_a, 32'h55);
      clear_fwd();
      step();

      // stall refresh on held rs2 = x4
      set_instr(32'h4C, 32'h1, 32'h99, 0, 1, 4, 12, 0, 0, 0, 1);
      step();
      in_valid = 0; out_ready = 0;
      mwb_reg_write = 1; mwb_rd = 4; mwb_data = 32'h1234;
      #1 check("stall_in_ready0", in_ready, 0);
      step();
      mwb_reg_write = 0;
      #1 check("stall_refresh", rs2_fwd, 32'h1234);
      check("stall_in_ready1", in_ready, 0);
      step();
      check("stall_refresh_hold", rs2_fwd, 32'h1234);
      check("stall_alu_b", alu_b, 32'h1234);
      check("stall_in_ready2", in_ready, 0);
      clear_fwd(); out_ready = 1;
      step();

      // shift masking vs. unmasked SUB
      set_instr(32'h50, 0, 0, 32'hFFFF_FFE3, 1, 2, 13, 0, 1, 7, 1);
      step();
      set_instr(32'h54, 0, 0, 32'hFFFF_FFE3, 1, 2, 14, 0, 1, 1, 1);
      #1 check("sra_mask", alu_b, 32'h0000_0003);
      step();
      in_valid = 0;
      check("sub_nomask", alu_b, 32'hFFFF_FFE3);
      check("sub_ctrl", alu_ctrl, 1);
      step();

      // flush beats accept; flush of stalled instruction
      set_instr(32'h58, 1, 2, 3, 1, 2, 15, 0, 0, 0, 1);
      flush = 1;
      step();
      flush = 0; in_valid = 0;
      check("flush_accept_drop", out_valid, 0);
      set_instr(32'h5C, 1, 2, 3, 1, 2, 16, 0, 0, 0, 1);
      out_ready = 0;
      step();
      in_valid = 0; flush = 1;
      step();
      flush = 0;
      check("flush_stall_valid", out_valid, 0);
      check("flush_stall_ready", in_ready, 1);
      out_ready = 1;
      step();

      // eight back-to-back accepts
      for (int i = 0; i < 8; i++) begin
         set_instr(32'h100 + 32'(4 * i), 32'(i), 32'(i + 100), 0, 1, 2, 5'(i + 1), 1, 0, 4'(i), 1);
         step();
         check("b2b_valid", out_valid, 1);
         check("b2b_pc", alu_a, 32'h100 + 32'(4 * i));
         check("b2b_rd", rd_addr, 32'(i + 1));
      end
      in_valid = 0;
      step();

      // random valid/ready toggling with random forwarding
      for (int i = 0; i < 60; i++) begin
         set_instr($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 1'($urandom));
         in_valid = 1'($urandom); out_ready = 1'($urandom);
         exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
         mwb_reg_write = 1'($urandom); mwb_rd = 5'($urandom_range(0, 7)); mwb_data = $urandom;
         flush = ($urandom_range(0, 15) == 0);
         step();
      end
      in_valid = 0; flush = 0; out_ready = 1; clear_fwd();
      step();
      step();

      // async reset mid-stall discards held instruction
      set_instr(32'hDEAD_0000, 32'h77, 32'h88, 0, 1, 2, 20, 1, 0, 0, 1);
      out_ready = 0;
      step();
      in_valid = 0;
      #1 rst_n = 0;
      #1 check("midrst_valid", out_valid, 0);
      check("midrst_alu_a", alu_a, 0);
      check("midrst_rs2_fwd", rs2_fwd, 0);
      step();
      step();
      rst_n = 1;
      step();
      step();
      check("postrst_valid", out_valid, 0);
      check("postrst_alu_a", alu_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
